// File: rtl/brownout_dig_mc.sv
// Multi-channel brownout controller: per-channel sync, debounce, one-shot hold,
// frozen trip-code decode and RC oscillator request.
module brownout_dig_mc #(
  parameter int NCH        = 2,
  parameter int TRIP_W     = 3,
  parameter int DEB_W      = 4,
  parameter int HOLD_W     = 16,
  parameter int LONG_HOLD  = 65535,
  parameter int SHORT_HOLD = 256
) (
  input  logic                        osc_ck,
  input  logic                        ena,
  input  logic [NCH-1:0]              brout_filt,
  input  logic [NCH*TRIP_W-1:0]       trip,
  input  logic [DEB_W-1:0]            deb_len,
  input  logic                        force_short_oneshot,
  input  logic                        force_rc_osc,
  output logic                        osc_ena,
  output logic [NCH-1:0]              out,
  output logic                        out_any,
  output logic [NCH*(2**TRIP_W)-1:0]  trip_decoded,
  output logic [NCH-1:0]              timed_out,
  output logic                        osc_ck_256,
  output logic [2*NCH-1:0]            state_dbg
);

  localparam int DEC_W = 2**TRIP_W;
  localparam logic [HOLD_W-1:0] LONG_LEN  = HOLD_W'(LONG_HOLD);
  localparam logic [HOLD_W-1:0] SHORT_LEN = HOLD_W'(SHORT_HOLD);
  localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_DEB   = 2'd1,
    ST_BROWN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            state_q [NCH];
  state_t            state_d [NCH];
  logic [HOLD_W-1:0] cnt_q   [NCH];
  logic [HOLD_W-1:0] cnt_d   [NCH];
  logic [HOLD_W-1:0] hold_q  [NCH];
  logic [HOLD_W-1:0] hold_d  [NCH];

  logic [NCH-1:0]    sync1_q;
  logic [NCH-1:0]    sync2_q;
  logic [NCH-1:0]    expire;
  logic [NCH-1:0]    flag_d;
  logic              any_busy;
  logic [7:0]        div_q;
  logic [HOLD_W-1:0] deb_ext;

  assign deb_ext = HOLD_W'(deb_len);

  // Next-state logic, one independent FSM per channel.
  // A '>=' debounce compare lets a shortened deb_len mid-DEB take effect at once.
  always_comb begin
    expire   = '0;
    flag_d   = '0;
    any_busy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hold_d[i]  = hold_q[i];
      case (state_q[i])
        ST_OK: begin
          if (sync2_q[i]) begin
            if (deb_len == '0) begin
              state_d[i] = ST_BROWN;
            end else begin
              state_d[i] = ST_DEB;
              cnt_d[i]   = '0;
            end
          end
        end
        ST_DEB: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_OK;
          end else if (deb_len == '0 || cnt_q[i] >= deb_ext - CNT_ONE) begin
            state_d[i] = ST_BROWN;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_BROWN: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_HOLD;
            cnt_d[i]   = '0;
            hold_d[i]  = force_short_oneshot ? SHORT_LEN : LONG_LEN;
          end
        end
        ST_HOLD: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_BROWN;
          end else if (cnt_q[i] == hold_q[i] - CNT_ONE) begin
            state_d[i] = ST_OK;
            expire[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: state_d[i] = ST_OK;
      endcase
      flag_d[i] = (state_d[i] == ST_BROWN) || (state_d[i] == ST_HOLD);
      if (state_q[i] != ST_OK) any_busy = 1'b1;
    end
  end

  always_comb begin
    state_dbg = '0;
    for (int i = 0; i < NCH; i++) begin
      state_dbg[2*i +: 2] = state_q[i];
    end
  end

  // The raw comparator term wakes the oscillator before any clock edge exists.
  assign osc_ena    = ena & (force_rc_osc | (|brout_filt) | any_busy);
  assign osc_ck_256 = div_q[7];

  always_ff @(posedge osc_ck or negedge ena) begin
    if (!ena) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      out       <= '0;
      out_any   <= 1'b0;
      timed_out <= '0;
      div_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_OK;
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
        trip_decoded[i*DEC_W +: DEC_W] <= DEC_W'(1);
      end
    end else begin
      sync1_q   <= brout_filt;
      sync2_q   <= sync1_q;
      out       <= flag_d;
      out_any   <= |flag_d;
      timed_out <= expire;
      div_q     <= div_q + 8'd1;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
        // Divider code is frozen for the whole event; reload only while idle.
        if (state_q[i] == ST_OK) begin
          trip_decoded[i*DEC_W +: DEC_W] <= DEC_W'(1) << trip[i*TRIP_W +: TRIP_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_brownout_dig_mc.sv
// Directed bench for brownout_dig_mc: debounce, hold, re-trigger, trip freeze,
// oscillator request, divider and asynchronous abort.
module tb_brownout_dig_mc;

  localparam int NCH        = 2;
  localparam int TRIP_W     = 3;
  localparam int DEB_W      = 4;
  localparam int HOLD_W     = 16;
  localparam int LONG_HOLD  = 600;
  localparam int SHORT_HOLD = 256;

  logic                        osc_ck = 1'b0;
  logic                        ena;
  logic [NCH-1:0]              brout_filt;
  logic [NCH*TRIP_W-1:0]       trip;
  logic [DEB_W-1:0]            deb_len;
  logic                        force_short_oneshot;
  logic                        force_rc_osc;
  logic                        osc_ena;
  logic [NCH-1:0]              out;
  logic                        out_any;
  logic [NCH*(2**TRIP_W)-1:0]  trip_decoded;
  logic [NCH-1:0]              timed_out;
  logic                        osc_ck_256;
  logic [2*NCH-1:0]            state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  brownout_dig_mc #(
    .NCH(NCH), .TRIP_W(TRIP_W), .DEB_W(DEB_W), .HOLD_W(HOLD_W),
    .LONG_HOLD(LONG_HOLD), .SHORT_HOLD(SHORT_HOLD)
  ) dut (
    .osc_ck(osc_ck), .ena(ena), .brout_filt(brout_filt), .trip(trip),
    .deb_len(deb_len), .force_short_oneshot(force_short_oneshot),
    .force_rc_osc(force_rc_osc), .osc_ena(osc_ena), .out(out), .out_any(out_any),
    .trip_decoded(trip_decoded), .timed_out(timed_out), .osc_ck_256(osc_ck_256),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 osc_ck = ~osc_ck;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge osc_ck);
      #1;
    end
  endtask

  task automatic test_reset();
    ena = 1'b0; brout_filt = 2'b11; trip = {3'd3, 3'd5}; deb_len = 4'd3;
    force_short_oneshot = 1'b1; force_rc_osc = 1'b0;
    tick(3);
    n_checks++; if (out !== 2'b00) begin n_fail++; $display("FAIL reset_out: got %b expected 00", out); end
    n_checks++; if (out_any !== 1'b0) begin n_fail++; $display("FAIL reset_out_any: got %b expected 0", out_any); end
    n_checks++; if (timed_out !== 2'b00) begin n_fail++; $display("FAIL reset_timed_out: got %b expected 00", timed_out); end
    n_checks++; if (trip_decoded !== 16'h0101) begin n_fail++; $display("FAIL reset_trip_decoded: got %h expected 0101", trip_decoded); end
    n_checks++; if (osc_ena !== 1'b0) begin n_fail++; $display("FAIL reset_osc_ena: got %b expected 0", osc_ena); end
    n_checks++; if (osc_ck_256 !== 1'b0) begin n_fail++; $display("FAIL reset_osc_ck_256: got %b expected 0", osc_ck_256); end
    brout_filt = 2'b00;
    ena = 1'b1;
    tick(1);
    n_checks++; if (trip_decoded !== 16'h0820) begin n_fail++; $display("FAIL release_trip_decoded: got %h expected 0820", trip_decoded); end
    n_checks++; if (osc_ena !== 1'b0) begin n_fail++; $display("FAIL idle_osc_ena: got %b expected 0", osc_ena); end
  endtask

  task automatic test_debounce();
    deb_len = 4'd3;
    brout_filt[0] = 1'b1;
    tick(2);
    brout_filt[0] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      n_checks++; if (out[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_out0 edge %0d: got %b expected 0", i, out[0]); end
    end
    brout_filt[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      n_checks++; if (out[0] !== 1'b0) begin n_fail++; $display("FAIL deb_early_out0 edge %0d: got %b expected 0", i, out[0]); end
    end
    tick(1);
    n_checks++; if (out !== 2'b01) begin n_fail++; $display("FAIL deb_out edge 6: got %b expected 01", out); end
    n_checks++; if (out_any !== 1'b1) begin n_fail++; $display("FAIL deb_out_any edge 6: got %b expected 1", out_any); end
  endtask

  task automatic test_trip_freeze();
    trip = {3'd3, 3'd2};
    tick(3);
    n_checks++; if (trip_decoded[7:0] !== 8'b0010_0000) begin n_fail++; $display("FAIL freeze_ch0: got %b expected 00100000", trip_decoded[7:0]); end
    n_checks++; if (trip_decoded[15:8] !== 8'b0000_1000) begin n_fail++; $display("FAIL freeze_ch1: got %b expected 00001000", trip_decoded[15:8]); end
  endtask

  task automatic test_retrigger();
    force_short_oneshot = 1'b1;
    brout_filt[0] = 1'b0;
    tick(3 + 97);
    brout_filt[0] = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      n_checks++; if (out[0] !== 1'b1 || timed_out[0] !== 1'b0) begin
        n_fail++; $display("FAIL retrig_hold edge %0d: got out=%b to=%b expected out=1 to=0", i, out[0], timed_out[0]);
      end
    end
    brout_filt[0] = 1'b0;
    for (int i = 1; i <= 258; i++) begin
      tick(1);
      n_checks++; if (out[0] !== 1'b1 || timed_out[0] !== 1'b0) begin
        n_fail++; $display("FAIL retrig_full_hold edge %0d: got out=%b to=%b expected out=1 to=0", i, out[0], timed_out[0]);
      end
    end
    tick(1);
    n_checks++; if (out[0] !== 1'b0) begin n_fail++; $display("FAIL retrig_expire_out0: got %b expected 0", out[0]); end
    n_checks++; if (timed_out !== 2'b01) begin n_fail++; $display("FAIL retrig_timed_out: got %b expected 01", timed_out); end
    n_checks++; if (trip_decoded[7:0] !== 8'b0010_0000) begin n_fail++; $display("FAIL trip_still_frozen: got %b expected 00100000", trip_decoded[7:0]); end
    n_checks++; if (out_any !== 1'b0) begin n_fail++; $display("FAIL retrig_out_any: got %b expected 0", out_any); end
    n_checks++; if (osc_ena !== 1'b0) begin n_fail++; $display("FAIL retrig_osc_ena: got %b expected 0", osc_ena); end
    tick(1);
    n_checks++; if (timed_out !== 2'b00) begin n_fail++; $display("FAIL retrig_pulse_width: got %b expected 00", timed_out); end
    n_checks++; if (trip_decoded[7:0] !== 8'b0000_0100) begin n_fail++; $display("FAIL trip_reload: got %b expected 00000100", trip_decoded[7:0]); end
  endtask

  task automatic test_hold();
    deb_len = 4'd0;
    force_short_oneshot = 1'b1;
    brout_filt[1] = 1'b1;
    #1;
    n_checks++; if (osc_ena !== 1'b1) begin n_fail++; $display("FAIL osc_wake: got %b expected 1", osc_ena); end
    force_rc_osc = 1'b1;
    tick(2);
    n_checks++; if (out[1] !== 1'b0) begin n_fail++; $display("FAIL nodeb_early_out1: got %b expected 0", out[1]); end
    tick(1);
    n_checks++; if (out[1] !== 1'b1) begin n_fail++; $display("FAIL nodeb_out1: got %b expected 1", out[1]); end
    brout_filt[1] = 1'b0;
    tick(258);
    n_checks++; if (out[1] !== 1'b1) begin n_fail++; $display("FAIL hold_out1_last: got %b expected 1", out[1]); end
    tick(1);
    n_checks++; if (out[1] !== 1'b0) begin n_fail++; $display("FAIL hold_out1_end: got %b expected 0", out[1]); end
    n_checks++; if (timed_out !== 2'b10) begin n_fail++; $display("FAIL hold_timed_out: got %b expected 10", timed_out); end
    n_checks++; if (osc_ena !== 1'b1) begin n_fail++; $display("FAIL forced_osc_ena: got %b expected 1", osc_ena); end
    tick(1);
    n_checks++; if (timed_out !== 2'b00) begin n_fail++; $display("FAIL hold_pulse_width: got %b expected 00", timed_out); end
    force_rc_osc = 1'b0;
    #1;
    n_checks++; if (osc_ena !== 1'b0) begin n_fail++; $display("FAIL unforced_osc_ena: got %b expected 0", osc_ena); end
  endtask

  task automatic test_long_hold();
    force_short_oneshot = 1'b0;
    brout_filt[1] = 1'b1;
    tick(3);
    brout_filt[1] = 1'b0;
    tick(3);
    force_short_oneshot = 1'b1;
    tick(599);
    n_checks++; if (out[1] !== 1'b1) begin n_fail++; $display("FAIL long_hold_last: got %b expected 1", out[1]); end
    tick(1);
    n_checks++; if (out[1] !== 1'b0 || timed_out[1] !== 1'b1) begin
      n_fail++; $display("FAIL long_hold_end: got out=%b to=%b expected out=0 to=1", out[1], timed_out[1]);
    end
  endtask

  task automatic test_back_to_back();
    deb_len = 4'd0;
    force_short_oneshot = 1'b1;
    brout_filt = 2'b11;
    tick(2);
    n_checks++; if (out !== 2'b00 || out_any !== 1'b0) begin
      n_fail++; $display("FAIL both_early: got out=%b any=%b expected out=00 any=0", out, out_any);
    end
    tick(1);
    n_checks++; if (out !== 2'b11 || out_any !== 1'b1) begin
      n_fail++; $display("FAIL both_out: got out=%b any=%b expected out=11 any=1", out, out_any);
    end
    brout_filt = 2'b00;
    tick(3 + 50);
    n_checks++; if (out !== 2'b11) begin n_fail++; $display("FAIL both_mid_hold: got %b expected 11", out); end
  endtask

  task automatic test_async_abort();
    ena = 1'b0;
    #1;
    n_checks++; if (out !== 2'b00 || out_any !== 1'b0) begin
      n_fail++; $display("FAIL abort_out: got out=%b any=%b expected out=00 any=0", out, out_any);
    end
    n_checks++; if (osc_ena !== 1'b0) begin n_fail++; $display("FAIL abort_osc_ena: got %b expected 0", osc_ena); end
    n_checks++; if (trip_decoded !== 16'h0101) begin n_fail++; $display("FAIL abort_trip_decoded: got %h expected 0101", trip_decoded); end
    #3;
    ena = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick(1);
      n_checks++; if (out !== 2'b00 || timed_out !== 2'b00) begin
        n_fail++; $display("FAIL post_abort edge %0d: got out=%b to=%b expected 00 00", i, out, timed_out);
      end
      if (i == 1) begin
        n_checks++; if (trip_decoded !== 16'h0804) begin n_fail++; $display("FAIL post_abort_trip: got %h expected 0804", trip_decoded); end
      end
      if (i == 127 || i == 256) begin
        n_checks++; if (osc_ck_256 !== 1'b0) begin n_fail++; $display("FAIL div edge %0d: got %b expected 0", i, osc_ck_256); end
      end
      if (i == 128 || i == 255) begin
        n_checks++; if (osc_ck_256 !== 1'b1) begin n_fail++; $display("FAIL div edge %0d: got %b expected 1", i, osc_ck_256); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_trip_freeze();
    test_retrigger();
    test_hold();
    test_long_hold();
    test_back_to_back();
    test_async_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
